// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and FSM encoding for the instruction
// memory loader.
//   DEPTH   - instruction memory depth in 32-bit words
//   ADDR_W  - word address width (log2 DEPTH)
//   state_t - loader FSM states
package imem_loader_pkg;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: assembles a big-endian 32-bit word from a byte stream.
//   i_clk        - clock
//   i_reset      - synchronous active-high reset
//   i_clr        - drop any partial word and restart at byte 0
//   i_shift      - a byte transfer happens this cycle
//   i_byte       - byte being transferred
//   o_word_nxt   - word as it will be after this cycle's byte is shifted in
//   o_word_full  - this transfer is the fourth byte of a word
module word_packer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_nxt,
  output logic        o_word_full
);
  logic [1:0]  r_idx;
  logic [31:0] r_buf;

  // First byte ends up in [31:24] after three further left shifts.
  assign o_word_nxt  = {r_buf[23:0], i_byte};
  assign o_word_full = i_shift && (r_idx == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (i_shift) begin
      r_idx <= r_idx + 2'd1;   // wraps to 0 after the fourth byte
      r_buf <= o_word_nxt;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream and writes it into
// instruction memory while holding the CPU in reset.
//   clk, reset          - clock, synchronous active-high reset
//   start, word_count   - load request and number of words (1..DEPTH)
//   byte_data/valid     - program byte stream, byte_ready = accepted this cycle
//   imem_we/addr/wdata  - instruction memory write port (addr/data 0 when idle)
//   cpu_reset           - held high from reset/start until a load completes
//   busy, done, err     - load in progress, sticky completion, bad-start pulse
module imem_loader #(
  parameter int DEPTH  = imem_loader_pkg::DEPTH,
  parameter int ADDR_W = imem_loader_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import imem_loader_pkg::*;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_widx;
  logic              r_busy, r_done, r_err, r_cpu_rst, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic        w_xfer, w_start_ok, w_clr, w_last, w_full;
  logic [31:0] w_word_nxt;

  assign w_xfer     = byte_valid && (r_state == RECV);
  assign w_start_ok = (word_count != '0) && (word_count <= L_DEPTH);
  assign w_clr      = (r_state == IDLE) && start && w_start_ok;
  assign w_last     = ({1'b0, r_widx} == (r_count - 1'b1));

  word_packer u_packer (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_clr       (w_clr),
    .i_shift     (w_xfer),
    .i_byte      (byte_data),
    .o_word_nxt  (w_word_nxt),
    .o_word_full (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_widx    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      // Write port and err are single-cycle pulses; bus is zero otherwise.
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_start_ok) begin
              r_count   <= word_count;
              r_widx    <= '0;
              r_done    <= 1'b0;
              r_busy    <= 1'b1;
              r_cpu_rst <= 1'b1;
              r_state   <= RECV;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (w_full) begin
            r_we    <= 1'b1;
            r_addr  <= r_widx;
            r_wdata <= w_word_nxt;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_widx  <= r_widx + 1'b1;
            r_state <= RECV;
          end
        end
        DONE: begin
          // Flags change on leaving DONE so done lands 5N+1 cycles after
          // the first byte.
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_cpu_rst <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign byte_ready = (r_state == RECV);
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = r_cpu_rst;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    byte_data = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, imem_we, cpu_reset, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  int n_hs     = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    stim_words[$];

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: pops the expected-write queue whenever the DUT writes.
  initial forever begin
    @(negedge clk); #2;
    if (byte_valid && byte_ready) n_hs++;
    if (imem_we) begin
      n_writes++;
      chk(exp_q.size() != 0, "unexpected_write", 64'(imem_addr), 64'(exp_q.size()));
      if (exp_q.size() != 0) begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk({imem_addr, imem_wdata} == e, "write_addr_data",
            64'({imem_addr, imem_wdata}), 64'(e));
      end
      chk(byte_ready == 1'b0, "ready_low_in_write", 64'(byte_ready), 0);
    end else begin
      chk({imem_addr, imem_wdata} == '0, "bus_zero_when_idle",
          64'({imem_addr, imem_wdata}), 0);
    end
  end

  // mode: 0 valid held high, 1 valid toggling, 2 random valid.
  // abort_at >= 0: assert reset once that many bytes have been accepted.
  task automatic do_load(input int n, input int mode, input int abort_at, input bit glitch);
    int  pos = 0, first = -1, hs0, wr0, guard = 0;
    bit  tog = 1'b1, glitched = 1'b0, prev_cpu = 1'b1, got_done = 1'b0;
    for (int i = 0; i < n; i++)
      if (abort_at < 0 || i < abort_at / 4)
        exp_q.push_back({AW'(i), stim_words[i]});
    hs0 = n_hs; wr0 = n_writes;
    @(negedge clk); start = 1'b1; word_count = (AW+1)'(n);
    @(negedge clk); start = 1'b0; word_count = (AW+1)'($urandom);
    #1;
    chk(busy && !done && cpu_reset, "start_accept_flags", {busy, done, cpu_reset}, 3'b101);
    while (guard < 8 * n + 40) begin
      if (guard > 0) begin @(negedge clk); #1; end
      guard++;
      if (done) begin got_done = 1'b1; break; end
      if (abort_at >= 0 && pos == abort_at) begin
        reset = 1'b1; byte_valid = 1'b0; break;
      end
      if (glitch && pos == 2 && !glitched) begin
        start = 1'b1; word_count = (AW+1)'(1); glitched = 1'b1;
      end else start = 1'b0;
      byte_valid = (pos < 4 * n) && (mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom));
      tog = ~tog;
      byte_data = (pos < 4 * n) ? 8'(stim_words[pos / 4] >> (24 - 8 * (pos % 4))) : 8'h00;
      if (byte_valid && byte_ready) begin
        if (first < 0) first = cyc;
        pos++;
      end
      prev_cpu = cpu_reset;
    end
    byte_valid = 1'b0; start = 1'b0;
    if (abort_at >= 0) begin
      @(negedge clk); #1;
      chk(!busy && !done && cpu_reset && !byte_ready && !imem_we, "abort_reset_state",
          {busy, done, cpu_reset, byte_ready, imem_we}, 5'b00100);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk(!done && cpu_reset && !busy, "abort_stays_idle", {done, cpu_reset, busy}, 3'b010);
      chk(n_writes - wr0 == abort_at / 4, "abort_write_count", n_writes - wr0, abort_at / 4);
    end else begin
      chk(got_done, "done_timeout", got_done, 1);
      chk(prev_cpu && !cpu_reset && !busy, "cpu_reset_falls_with_done",
          {prev_cpu, cpu_reset, busy}, 3'b100);
      chk(pos == 4 * n && n_hs - hs0 == 4 * n, "bytes_consumed", n_hs - hs0, 4 * n);
      chk(n_writes - wr0 == n, "write_count", n_writes - wr0, n);
      if (mode == 0) chk(cyc - first == 5 * n + 1, "load_latency", cyc - first, 5 * n + 1);
    end
    chk(exp_q.size() == 0, "pending_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic bad_start(input int wc);
    bit d0, c0;
    int wr0;
    d0 = done; c0 = cpu_reset; wr0 = n_writes;
    @(negedge clk); start = 1'b1; word_count = (AW+1)'(wc);
    @(negedge clk); start = 1'b0; #1;
    chk(err == 1'b1 && !busy && !byte_ready, "err_pulse", {err, busy, byte_ready}, 3'b100);
    @(negedge clk); #1;
    chk(err == 1'b0, "err_one_cycle", err, 0);
    chk(done == d0 && cpu_reset == c0 && !busy, "err_state_unchanged",
        {done, cpu_reset, busy}, {d0, c0, 1'b0});
    chk(n_writes == wr0, "err_no_write", n_writes - wr0, 0);
  endtask

  task automatic rand_words(input int n);
    stim_words.delete();
    for (int i = 0; i < n; i++) stim_words.push_back($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk({busy, done, err, imem_we, byte_ready} == '0 && cpu_reset, "reset_state",
        {busy, done, err, imem_we, byte_ready, cpu_reset}, 6'b000001);
    reset = 1'b0;

    stim_words.delete();
    stim_words.push_back(32'h8C010004);
    stim_words.push_back(32'hAC020008);
    do_load(2, 0, -1, 1'b0);

    bad_start(0);
    bad_start(DEPTH + 1);

    rand_words(1);  do_load(1, 1, -1, 1'b0);
    rand_words(3);  do_load(3, 0, 6, 1'b0);
    bad_start(0);
    rand_words(3);  do_load(3, 0, -1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 8);
      rand_words(n);
      do_load(n, $urandom_range(0, 2), -1, 1'b0);
    end
    rand_words(DEPTH); do_load(DEPTH, 0, -1, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning instruction-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning word-address width (log2 DEPTH).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning reset, which is synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  meaning a one-cycle load request.
REQ-006 The block SHALL have port word_count  input  ADDR_W+1  meaning the number of words to load; it is sampled with start.
REQ-007 The block SHALL have port byte_data  input  8  meaning the program byte stream.
REQ-008 The block SHALL have port byte_valid  input  1  meaning byte_data is valid.
REQ-009 The block SHALL have port byte_ready  output  1  meaning the block accepts a byte this cycle.
REQ-010 The block SHALL have port imem_we  output  1  meaning instruction-memory write strobe.
REQ-011 The block SHALL have port imem_addr  output  ADDR_W  meaning instruction-memory word address.
REQ-012 The block SHALL have port imem_wdata  output  32  meaning the instruction word to write.
REQ-013 The block SHALL have port cpu_reset  output  1  meaning hold the pipeline in reset.
REQ-014 The block SHALL have port busy  output  1  meaning a load is in progress.
REQ-015 The block SHALL have port done  output  1  meaning the last load completed (sticky).
REQ-016 The block SHALL have port err  output  1  meaning an illegal start request (one-cycle pulse).

Function
REQ-017 The state machine SHALL have exactly the states IDLE, RECV, WRITE and DONE.
REQ-018 In IDLE, start with 1 <= word_count <= DEPTH SHALL, on the next cycle, latch the count, clear the word index and byte index, clear done, assert busy and cpu_reset, and enter RECV.
REQ-019 In IDLE, start with word_count == 0 or word_count > DEPTH SHALL pulse err for exactly one cycle and leave state, done and cpu_reset unchanged.
REQ-020 start SHALL be ignored in every state except IDLE.
REQ-021 byte_ready SHALL be 1 only in RECV; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-022 Bytes SHALL pack big-endian: the first byte goes to [31:24] and the fourth byte to [7:0].
REQ-023 A byte_valid pulse that arrives while byte_ready is 0 SHALL NOT be consumed; the source holds byte_data until it is accepted.
REQ-024 The cycle after the fourth transfer SHALL be WRITE, with imem_we=1 for exactly one cycle, imem_addr=word index and imem_wdata=the packed word.
REQ-025 From WRITE, if word index == count-1 the next state SHALL be DONE; otherwise the word index increments and the next state is RECV.
REQ-026 In DONE for one cycle, busy SHALL drop, done SHALL set and cpu_reset SHALL deassert; the next state is IDLE.
REQ-027 done SHALL stay at 1 and cpu_reset SHALL stay at 0 until the next accepted start or reset.
REQ-028 A load of N words SHALL take exactly 5N+1 cycles from the first accepted byte to done=1, assuming byte_valid is held at 1.
REQ-029 imem_addr and imem_wdata SHALL be 0 whenever imem_we is 0.
REQ-030 word_count == DEPTH SHALL write addresses 0..DEPTH-1 with no wrap-around.

Reset
REQ-031 While reset is high, the block SHALL be in IDLE with busy, done, err, imem_we, byte_ready, imem_addr and imem_wdata all 0, and cpu_reset = 1.
REQ-032 Reset asserted mid-load SHALL abort the load on the next edge: no further imem_we is issued, the partial word is discarded, and done stays 0.

Structure
REQ-033 Package imem_loader_pkg SHALL hold DEPTH, ADDR_W and the state encoding (IDLE=0, RECV=1, WRITE=2, DONE=3).
REQ-034 Sub-module word_packer SHALL contain the 2-bit byte index and the 32-bit shift buffer, and assert word_full after the fourth byte.
REQ-035 The top level SHALL contain the FSM, the word index, the count latch and the output registers.

Verification
REQ-036 Reset, then start with word_count=2 and bytes 8C,01,00,04,AC,02,00,08 held valid -> imem_we at addr 0 with 0x8C010004, then at addr 1 with 0xAC020008; done=1 after 11 cycles; cpu_reset falls at the same time as done rises.
REQ-037 start with word_count=0, then start with word_count=1025 -> err pulses one cycle each, state stays IDLE, imem_we never asserts.
REQ-038 word_count=1 with byte_valid toggling 1,0,1,0... -> exactly 4 bytes consumed, one write of the correct word, byte_ready=0 during WRITE.
REQ-039 Reset asserted after 6 bytes of a 3-word load -> only addr 0 is written, cpu_reset=1, done=0, busy=0.
REQ-040 start pulsed during RECV -> ignored, and the count stays at its original value; word_count=1024 -> the final write is at addr 1023 and done sets.
